d5m_frame_gen: RTL
==================

# d5m_frame_gen

- Synthesizable D5M-style pixel-stream transmitter that drives frame-valid, line-valid and 12-bit pixel data with D5M timing.
- Acts as the source end of the camera interface that the image-processing capture path consumes, so capture, pixel counting and DMEM packing can be exercised on hardware and in simulation without a physical D5M.
- Generates software-selectable test patterns, single-shot or continuous, with deterministic per-frame content.

## Interface
- PIX_DIV, 1 — system clocks per pixel strobe (≥1).
- H_ACTIVE, 640 — pixels per line with LVAL high (≥1).
- V_ACTIVE, 480 — active lines per frame (≥1).
- H_BLANK, 16 — pixel strobes of LVAL low before the first line and after every line (≥1).
- V_BLANK, 32 — pixel strobes of FVAL low after each frame (≥1).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  block enable; triggers are ignored while low.
- trigger  in  1  one-cycle or longer request for one frame.
- continuous  in  1  when high, frames repeat back to back while enable is high.
- mode  in  2  pattern select, sampled at frame start.
- pix_stb  out  1  one-cycle pixel qualifier; all D5M outputs change only on cycles with pix_stb high.
- d5m_fval  out  1  frame valid.
- d5m_lval  out  1  line valid.
- d5m_d  out  12  pixel data; 0 whenever d5m_lval is low.
- busy  out  1  high from frame start through the last V_BLANK strobe.
- frame_done  out  1  one-clk pulse on the last V_BLANK strobe.
- frame_cnt  out  16  completed frames; wraps from 16'hFFFF to 0.

## Operation
- Strobe divider:
  - counts 0..PIX_DIV-1;
  - pix_stb is high when the count equals PIX_DIV-1;
  - with PIX_DIV=1, pix_stb is high every cycle.
- Trigger handling:
  - trigger high while enable is high and the state is IDLE sets a pending flag;
  - trigger is ignored in any other state.
- States, with every transition taken on a pix_stb cycle:
  - IDLE: fval=0, lval=0. If pending or (continuous and enable), clear pending, latch mode, clear row/col, go to F_PRE.
  - F_PRE: fval=1, lval=0, H_BLANK strobes, then go to LINE.
  - LINE: fval=1, lval=1, H_ACTIVE strobes; col increments each strobe.
  - HB: fval=1, lval=0, H_BLANK strobes; row increments on entry, col is cleared. At the end, go to LINE if row<V_ACTIVE, otherwise go to VB.
  - VB: fval=0, V_BLANK strobes. On the last strobe: frame_done=1 and frame_cnt+1. Then, if continuous and enable, go straight to F_PRE (zero IDLE strobes); otherwise go to IDLE.
- Patterns, selected by the mode latched at frame start:
  - 0: horizontal ramp, col[11:0].
  - 1: vertical ramp, row[11:0].
  - 2: checker, 12'hFFF when col[3]^row[3], else 0.
  - 3: see Configuration.
- Mid-frame changes:
  - enable dropping mid-frame: the current frame completes, then the block goes to IDLE.
  - changes on mode or continuous mid-frame: take effect at the next frame start.

## Timing
- All outputs are registered.
- Reset values: pix_stb=0, d5m_fval=0, d5m_lval=0, d5m_d=0, busy=0, frame_done=0, frame_cnt=0. The pending flag and divider are also cleared.
- Reset asserted mid-frame clears everything at once; there is no partial frame afterwards.
- Latency with PIX_DIV=1: trigger high at edge N sets pending; d5m_fval goes high after edge N+1.
- Frame length in pix_stb periods:
  - FVAL high = H_BLANK + V_ACTIVE×(H_ACTIVE+H_BLANK);
  - FVAL low = V_BLANK.
- Continuous mode has no extra gap: the next FVAL rises on the strobe after the last VB strobe.
- d5m_d is valid exactly on the strobes where d5m_lval is high, and is aligned with d5m_lval.
- Simultaneous events:
  - trigger coinciding with the VB→IDLE strobe is ignored, because the state is not yet IDLE;
  - trigger in IDLE coinciding with a strobe is consumed on the following strobe.

## Configuration
- D5M_GEN_LFSR_EN defined: mode 3 outputs a 12-bit Fibonacci LFSR.
  - Taps: 12, 11, 10, 4.
  - Seeded to 12'hACE at frame start.
  - Advances on every LINE strobe; d5m_d equals the LFSR value.
- D5M_GEN_LFSR_EN undefined: no LFSR logic; mode 3 outputs constant 12'h800 during LVAL.

## Test plan
- Small frame (H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, V_BLANK=5, PIX_DIV=1), mode 0, single trigger -> FVAL high 20 cycles; 3 LVAL pulses of 4 cycles; d5m_d per line 0,1,2,3; one frame_done; frame_cnt=1; busy low afterwards.
- Same frame with continuous=1 -> period exactly 25 cycles; FVAL low exactly 5 cycles; frame_cnt increments every 25 cycles; enable dropped mid-frame -> that frame finishes, then IDLE.
- PIX_DIV=3, mode 1 -> pix_stb every 3rd cycle; outputs change only on pix_stb; line k carries value k; FVAL high 60 cycles.
- Reset asserted during LINE of row 1 -> all outputs 0 at once; after release, no FVAL until a new trigger.
- Trigger asserted during F_PRE and during VB -> ignored; exactly one frame produced. Trigger with enable=0 -> no frame.
- Mode 3 with D5M_GEN_LFSR_EN -> first pixel of every frame is the LFSR step after 12'hACE; two frames identical. Without the macro -> all active pixels 12'h800.

Source files
------------

// File: rtl/d5m_frame_gen.sv
// D5M-style pixel-stream source: FVAL/LVAL/12-bit data with programmable geometry and test patterns.
// Optional macro D5M_GEN_LFSR_EN turns mode 3 into a 12-bit LFSR pattern (otherwise a constant 12'h800).
module d5m_frame_gen #(
    parameter int PIX_DIV  = 1,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        trigger,
    input  logic        continuous,
    input  logic [1:0]  mode,
    output logic        pix_stb,
    output logic        d5m_fval,
    output logic        d5m_lval,
    output logic [11:0] d5m_d,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int          DIV_W      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [15:0] HA_LAST    = 16'(H_ACTIVE - 1);
    localparam logic [15:0] HB_LAST    = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST    = 16'(V_BLANK - 1);
    localparam logic [15:0] V_LINES    = 16'(V_ACTIVE);
    localparam logic [11:0] LFSR_SEED  = 12'hACE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FPRE,
        S_LINE,
        S_HB,
        S_VB
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       col_q, col_d;
    logic [15:0]       row_q, row_d;
    logic [1:0]        mode_q, mode_d;
    logic              pend_q, pend_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              done_d;
    logic              start;
    logic              stb;
    logic [11:0]       pix_d;

    logic              pix_stb_q, fval_q, lval_q, busy_q, done_q;
    logic [11:0]       d_q;

    assign stb   = (div_q == DIV_LAST);
    assign div_d = stb ? '0 : div_q + 1'b1;

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        start   = 1'b0;

        if (trigger && enable && (state_q == S_IDLE)) begin
            pend_d = 1'b1;
        end

        if (stb) begin
            unique case (state_q)
                S_IDLE: begin
                    if (pend_q || (continuous && enable)) start = 1'b1;
                end
                S_FPRE: begin
                    if (cnt_q == HB_LAST) begin
                        state_d = S_LINE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_LINE: begin
                    if (col_q == HA_LAST) begin
                        state_d = S_HB;
                        row_d   = row_q + 16'd1;
                        col_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
                S_HB: begin
                    if (cnt_q == HB_LAST) begin
                        cnt_d   = '0;
                        state_d = (row_q < V_LINES) ? S_LINE : S_VB;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_VB: begin
                    if (cnt_q == VB_LAST) begin
                        if (continuous && enable) start = 1'b1;
                        else                      state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Consuming the request wins over a trigger arriving on the same cycle.
            if (start) begin
                state_d = S_FPRE;
                pend_d  = 1'b0;
                mode_d  = mode;
                row_d   = '0;
                col_d   = '0;
                cnt_d   = '0;
            end

            // frame_done is flagged as the last V_BLANK strobe goes out, not after it.
            if ((state_d == S_VB) && (cnt_d == VB_LAST)) begin
                done_d = 1'b1;
                fcnt_d = fcnt_q + 16'd1;
            end
        end
    end

`ifdef D5M_GEN_LFSR_EN
    logic [11:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (start) begin
            lfsr_d = LFSR_SEED;
        end else if (stb && (state_d == S_LINE)) begin
            lfsr_d = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= '0;
        else     lfsr_q <= lfsr_d;
    end
`endif

    // Data is derived from next-state values so it registers in step with LVAL.
    always_comb begin
        pix_d = 12'h000;
        if (state_d == S_LINE) begin
            unique case (mode_d)
                2'd0: pix_d = col_d[11:0];
                2'd1: pix_d = row_d[11:0];
                2'd2: pix_d = (col_d[3] ^ row_d[3]) ? 12'hFFF : 12'h000;
`ifdef D5M_GEN_LFSR_EN
                2'd3: pix_d = lfsr_d;
`else
                2'd3: pix_d = 12'h800;
`endif
                default: pix_d = 12'h000;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            mode_q    <= '0;
            pend_q    <= 1'b0;
            fcnt_q    <= '0;
            pix_stb_q <= 1'b0;
            fval_q    <= 1'b0;
            lval_q    <= 1'b0;
            d_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            fcnt_q    <= fcnt_d;
            pix_stb_q <= stb;
            fval_q    <= (state_d == S_FPRE) || (state_d == S_LINE) || (state_d == S_HB);
            lval_q    <= (state_d == S_LINE);
            d_q       <= pix_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= done_d;
        end
    end

    assign pix_stb    = pix_stb_q;
    assign d5m_fval   = fval_q;
    assign d5m_lval   = lval_q;
    assign d5m_d      = d_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule
